// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared widths and buffered-entry type for the register-file
//               write-port arbiter (wb_arbiter / wb_arb_fifo).
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    // One buffered secondary writeback. The arbiter's DATA_W/ADDR_W
    // parameters must stay equal to these widths.
    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_arb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_fifo
// Description : DEPTH-entry buffer for secondary writebacks. Slot 0 is the
//               head and the fill count is the tail index; entries are kept
//               packed towards the head, so popped and squashed entries are
//               dropped from the order immediately and never take a slot.
//               Provides squash-by-address and two hazard address compares.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [WB_ADDR_W-1:0] push_addr_i,
    input  logic [WB_DATA_W-1:0] push_data_i,
    input  logic                 pop_i,
    input  logic                 squash_i,
    input  logic [WB_ADDR_W-1:0] squash_addr_i,
    input  logic [WB_ADDR_W-1:0] rs_addr_i,
    input  logic [WB_ADDR_W-1:0] rt_addr_i,
    output wb_entry_t            head_o,
    output logic                 head_squash_o,
    output logic [CNT_W-1:0]     count_o,
    output logic                 rs_hit_o,
    output logic                 rt_hit_o
);

    wb_entry_t        buf_q [DEPTH];
    wb_entry_t        buf_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [DEPTH-1:0] w_kill;
    logic [DEPTH-1:0] w_rs_hit;
    logic [DEPTH-1:0] w_rt_hit;
    logic             w_push_kill;

    // Per-entry squash match and hazard compares (register 0 never hazards).
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign w_kill[g]   = squash_i && buf_q[g].valid && (buf_q[g].addr == squash_addr_i);
        assign w_rs_hit[g] = buf_q[g].valid && (buf_q[g].addr != '0) && (buf_q[g].addr == rs_addr_i);
        assign w_rt_hit[g] = buf_q[g].valid && (buf_q[g].addr != '0) && (buf_q[g].addr == rt_addr_i);
    end

    // An incoming entry for the address the primary is writing is older
    // than the primary result, so it is dropped on arrival.
    assign w_push_kill = squash_i && (push_addr_i == squash_addr_i);

    // Next buffer: survivors shifted towards the head in order, then the push.
    always_comb begin
        int fill;
        fill = 0;
        for (int j = 0; j < DEPTH; j++) begin
            buf_d[j] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (buf_q[i].valid && !w_kill[i] && !(pop_i && (i == 0))) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == fill) begin
                        buf_d[j] = buf_q[i];
                    end
                end
                fill = fill + 1;
            end
        end
        if (push_i && !w_push_kill) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j == fill) begin
                    buf_d[j].valid = 1'b1;
                    buf_d[j].addr  = push_addr_i;
                    buf_d[j].data  = push_data_i;
                end
            end
            fill = fill + 1;
        end
        count_d = CNT_W'(fill);
    end

    // Buffer state register; reset discards every entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
            end
            count_q <= count_d;
        end
    end

    assign head_o        = buf_q[0];
    assign head_squash_o = w_kill[0];
    assign count_o       = count_q;
    assign rs_hit_o      = |w_rs_hit;
    assign rt_hit_o      = |w_rt_hit;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Merges the in-order pipeline writeback (always granted) and a
//               buffered multi-cycle unit writeback onto the single register
//               file write port. Squashes older buffered writes to the same
//               register, reports RAW hazards against buffered entries and
//               flags starvation of the buffer head.
// Options     : WB_ARB_R0_FILTER_EN - drop writes to register 0 from both
//               sources (secondary handshake still completes).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W   = WB_DATA_W,
    parameter int ADDR_W   = WB_ADDR_W,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   Pwr_i,
    input  logic [ADDR_W-1:0]      Paddr_i,
    input  logic [DATA_W-1:0]      Pdata_i,
    input  logic                   Svalid_i,
    input  logic [ADDR_W-1:0]      Saddr_i,
    input  logic [DATA_W-1:0]      Sdata_i,
    output logic                   Sready_o,
    input  logic [ADDR_W-1:0]      RSaddr_i,
    input  logic [ADDR_W-1:0]      RTaddr_i,
    output logic                   RegWrite_o,
    output logic [ADDR_W-1:0]      RDaddr_o,
    output logic [DATA_W-1:0]      RDdata_o,
    output logic                   hazard_o,
    output logic                   starve_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int                CNT_W      = $clog2(DEPTH) + 1;
    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  c_DEPTH    = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] c_MAX_WAIT = WAIT_W'(MAX_WAIT);

    wb_entry_t          w_head;
    logic               w_head_squash;
    logic [CNT_W-1:0]   w_count;
    logic               w_rs_hit;
    logic               w_rt_hit;
    logic               w_pri_wr;
    logic               w_sec_keep;
    logic               w_push;
    logic               w_pop;

    logic               RegWrite_q, RegWrite_d;
    logic [ADDR_W-1:0]  RDaddr_q, RDaddr_d;
    logic [DATA_W-1:0]  RDdata_q, RDdata_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

`ifdef WB_ARB_R0_FILTER_EN
    // A primary write to r0 still owns the port this cycle but writes nothing.
    assign w_pri_wr   = Pwr_i && (Paddr_i != '0);
    assign w_sec_keep = (Saddr_i != '0);
`else
    assign w_pri_wr   = Pwr_i;
    assign w_sec_keep = 1'b1;
`endif

    // Ready depends only on occupancy at the start of the cycle, so a full
    // buffer refuses a push even when the head pops in the same cycle.
    assign Sready_o = !rst_i && (w_count < c_DEPTH);
    assign w_push   = Svalid_i && Sready_o && w_sec_keep;
    assign w_pop    = !Pwr_i && w_head.valid;

    wb_arb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (w_push),
        .push_addr_i   (Saddr_i),
        .push_data_i   (Sdata_i),
        .pop_i         (w_pop),
        .squash_i      (w_pri_wr),
        .squash_addr_i (Paddr_i),
        .rs_addr_i     (RSaddr_i),
        .rt_addr_i     (RTaddr_i),
        .head_o        (w_head),
        .head_squash_o (w_head_squash),
        .count_o       (w_count),
        .rs_hit_o      (w_rs_hit),
        .rt_hit_o      (w_rt_hit)
    );

    // Grant mux: primary first, otherwise drain the head; idle holds addr/data.
    always_comb begin
        RegWrite_d = 1'b0;
        RDaddr_d   = RDaddr_q;
        RDdata_d   = RDdata_q;
        if (w_pri_wr) begin
            RegWrite_d = 1'b1;
            RDaddr_d   = Paddr_i;
            RDdata_d   = Pdata_i;
        end else if (w_pop) begin
            RegWrite_d = 1'b1;
            RDaddr_d   = w_head.addr;
            RDdata_d   = w_head.data;
        end
    end

    // Head wait counter: restarts whenever the head leaves or the buffer is
    // empty, and saturates once the starvation threshold is reached.
    always_comb begin
        wait_d = wait_q;
        if (!w_head.valid || w_pop || w_head_squash) begin
            wait_d = '0;
        end else if (wait_q < c_MAX_WAIT) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // Write-port output registers and wait counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            RegWrite_q <= 1'b0;
            RDaddr_q   <= '0;
            RDdata_q   <= '0;
            wait_q     <= '0;
        end else begin
            RegWrite_q <= RegWrite_d;
            RDaddr_q   <= RDaddr_d;
            RDdata_q   <= RDdata_d;
            wait_q     <= wait_d;
        end
    end

    assign RegWrite_o = RegWrite_q;
    assign RDaddr_o   = RDaddr_q;
    assign RDdata_o   = RDdata_q;
    assign hazard_o   = w_rs_hit || w_rt_hit;
    assign starve_o   = (wait_q >= c_MAX_WAIT);
    assign count_o    = w_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter: directed scenarios with
//               fixed expectations plus randomized traffic compared against a
//               queue-based reference model. Honours WB_ARB_R0_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
    localparam int CW       = $clog2(DEPTH) + 1;
`ifdef WB_ARB_R0_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              Pwr = 1'b0;
    logic [ADDR_W-1:0] Paddr = '0;
    logic [DATA_W-1:0] Pdata = '0;
    logic              Svalid = 1'b0;
    logic [ADDR_W-1:0] Saddr = '0;
    logic [DATA_W-1:0] Sdata = '0;
    logic [ADDR_W-1:0] RSaddr = '0;
    logic [ADDR_W-1:0] RTaddr = '0;
    logic              Sready_o, RegWrite_o, hazard_o, starve_o;
    logic [ADDR_W-1:0] RDaddr_o;
    logic [DATA_W-1:0] RDdata_o;
    logic [CW-1:0]     count_o;
    logic [42:0]       dut_vec;

    int n_checks = 0;
    int n_pass   = 0;

    wb_arbiter #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH), .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk_i (clk), .rst_i (rst),
        .Pwr_i (Pwr), .Paddr_i (Paddr), .Pdata_i (Pdata),
        .Svalid_i (Svalid), .Saddr_i (Saddr), .Sdata_i (Sdata), .Sready_o (Sready_o),
        .RSaddr_i (RSaddr), .RTaddr_i (RTaddr),
        .RegWrite_o (RegWrite_o), .RDaddr_o (RDaddr_o), .RDdata_o (RDdata_o),
        .hazard_o (hazard_o), .starve_o (starve_o), .count_o (count_o)
    );

    always #5 clk = ~clk;

    assign dut_vec = {RegWrite_o, RDaddr_o, RDdata_o, count_o, starve_o, hazard_o, Sready_o};

    // ---------------- reference model: a queue of pending writes ----------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              m_q[$];
    logic              m_we   = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    int                m_wait = 0;

    always @(posedge clk) begin : model
        int   pre;
        bit   acc, pri_wr, popped, head_gone;
        ent_t kept[$];
        ent_t e;
        pre = m_q.size();
        if (rst) begin
            m_q.delete();
            m_we = 1'b0; m_addr = '0; m_data = '0; m_wait = 0;
        end else begin
            acc       = Svalid && (pre < DEPTH);
            pri_wr    = Pwr && !(FILT && (Paddr == 0));
            popped    = 1'b0;
            head_gone = 1'b0;
            if (Pwr) begin
                m_we = pri_wr;
                if (pri_wr) begin
                    m_addr = Paddr;
                    m_data = Pdata;
                    if (pre > 0 && m_q[0].addr == Paddr) head_gone = 1'b1;
                    kept.delete();
                    foreach (m_q[k]) if (m_q[k].addr != Paddr) kept.push_back(m_q[k]);
                    m_q = kept;
                end
            end else if (pre > 0) begin
                m_we   = 1'b1;
                m_addr = m_q[0].addr;
                m_data = m_q[0].data;
                void'(m_q.pop_front());
                popped = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            if (acc && !(FILT && (Saddr == 0)) && !(pri_wr && (Saddr == Paddr))) begin
                e.addr = Saddr;
                e.data = Sdata;
                m_q.push_back(e);
            end
            if (pre == 0 || popped || head_gone) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
        end
    end

    function automatic logic m_haz();
        foreach (m_q[k])
            if (m_q[k].addr != 0 && (m_q[k].addr == RSaddr || m_q[k].addr == RTaddr)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [42:0] m_vec();
        return {m_we, m_addr, m_data, CW'(m_q.size()), (m_wait >= MAX_WAIT), m_haz(),
                (!rst && (m_q.size() < DEPTH))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ------------------------------------------
    task automatic test_reset();
        rst = 1'b1; Pwr = 1'b1; Paddr = 5'd9; Pdata = 32'hFFFF_0000;
        Svalid = 1'b1; Saddr = 5'd3; Sdata = 32'h1; RSaddr = 5'd3; RTaddr = 5'd3;
        tick(); tick();
        n_checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o} !== 38'd0)
            $display("FAIL reset_wr: got %h expected 0", {RegWrite_o, RDaddr_o, RDdata_o});
        else n_pass++;
        n_checks++;
        if ({count_o, starve_o, hazard_o, Sready_o} !== 5'd0)
            $display("FAIL reset_state: got %b expected 00000", {count_o, starve_o, hazard_o, Sready_o});
        else n_pass++;
        rst = 1'b0; Pwr = 1'b0; Svalid = 1'b0;
        #1;
        n_checks++;
        if (Sready_o !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", Sready_o);
        else n_pass++;
    endtask

    task automatic test_primary();
        Pwr = 1'b1; Paddr = 5'd5; Pdata = 32'hDEAD_BEEF; RSaddr = 5'd5; RTaddr = 5'd5;
        tick();
        n_checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, hazard_o} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0})
            $display("FAIL primary: got %h expected %h", {RegWrite_o, RDaddr_o, RDdata_o, hazard_o},
                     {1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0});
        else n_pass++;
        Pwr = 1'b0;
        tick();
        n_checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o} !== {1'b0, 5'd5, 32'hDEAD_BEEF})
            $display("FAIL primary_idle_hold: got %h expected %h", {RegWrite_o, RDaddr_o, RDdata_o},
                     {1'b0, 5'd5, 32'hDEAD_BEEF});
        else n_pass++;
    endtask

    task automatic test_fill();
        Pwr = 1'b1; Paddr = 5'd9; Pdata = 32'h99; RSaddr = 5'd0; RTaddr = 5'd0;
        Svalid = 1'b1; Saddr = 5'd3; Sdata = 32'h11;
        tick();
        Saddr = 5'd4; Sdata = 32'h22;
        tick();
        n_checks++;
        if ({Sready_o, count_o, RegWrite_o, RDaddr_o} !== {1'b0, 2'd2, 1'b1, 5'd9})
            $display("FAIL fill_full: got %h expected %h", {Sready_o, count_o, RegWrite_o, RDaddr_o},
                     {1'b0, 2'd2, 1'b1, 5'd9});
        else n_pass++;
        Svalid = 1'b0; RSaddr = 5'd3;
        #1;
        n_checks++;
        if (hazard_o !== 1'b1) $display("FAIL fill_hazard_rs: got %b expected 1", hazard_o);
        else n_pass++;
        RSaddr = 5'd9; RTaddr = 5'd4;
        #1;
        n_checks++;
        if (hazard_o !== 1'b1) $display("FAIL fill_hazard_rt: got %b expected 1", hazard_o);
        else n_pass++;
        RTaddr = 5'd0;
        #1;
        n_checks++;
        if (hazard_o !== 1'b0) $display("FAIL fill_no_hazard: got %b expected 0", hazard_o);
        else n_pass++;
        Pwr = 1'b0;
        tick();
        n_checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o} !== {1'b1, 5'd3, 32'h11})
            $display("FAIL fill_drain1: got %h expected %h", {RegWrite_o, RDaddr_o, RDdata_o}, {1'b1, 5'd3, 32'h11});
        else n_pass++;
        tick();
        n_checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o} !== {1'b1, 5'd4, 32'h22})
            $display("FAIL fill_drain2: got %h expected %h", {RegWrite_o, RDaddr_o, RDdata_o}, {1'b1, 5'd4, 32'h22});
        else n_pass++;
        tick();
        n_checks++;
        if ({RegWrite_o, count_o} !== {1'b0, 2'd0})
            $display("FAIL fill_empty: got %b expected 000", {RegWrite_o, count_o});
        else n_pass++;
    endtask

    task automatic test_squash();
        Pwr = 1'b0; Svalid = 1'b1; Saddr = 5'd7; Sdata = 32'hAA;
        tick();
        n_checks++;
        if (count_o !== 2'd1) $display("FAIL squash_buffered: got %0d expected 1", count_o);
        else n_pass++;
        Svalid = 1'b0; Pwr = 1'b1; Paddr = 5'd7; Pdata = 32'h55;
        tick();
        n_checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, count_o} !== {1'b1, 5'd7, 32'h55, 2'd0})
            $display("FAIL squash_primary: got %h expected %h", {RegWrite_o, RDaddr_o, RDdata_o, count_o},
                     {1'b1, 5'd7, 32'h55, 2'd0});
        else n_pass++;
        Pwr = 1'b0;
        tick();
        n_checks++;
        if ({RegWrite_o, RDdata_o} !== {1'b0, 32'h55})
            $display("FAIL squash_no_old_write: got %h expected %h", {RegWrite_o, RDdata_o}, {1'b0, 32'h55});
        else n_pass++;
        Pwr = 1'b1; Paddr = 5'd8; Pdata = 32'h66; Svalid = 1'b1; Saddr = 5'd8; Sdata = 32'hBB;
        tick();
        Pwr = 1'b0; Svalid = 1'b0;
        n_checks++;
        if ({count_o, RDdata_o} !== {2'd0, 32'h66})
            $display("FAIL squash_same_cycle: got %h expected %h", {count_o, RDdata_o}, {2'd0, 32'h66});
        else n_pass++;
        tick();
        n_checks++;
        if (RegWrite_o !== 1'b0) $display("FAIL squash_same_cycle_idle: got %b expected 0", RegWrite_o);
        else n_pass++;
    endtask

    task automatic test_starve();
        Pwr = 1'b1; Paddr = 5'd1; Pdata = 32'h1; Svalid = 1'b1; Saddr = 5'd12; Sdata = 32'h1234;
        tick();
        Svalid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_checks++;
            if (starve_o !== (c >= 4)) $display("FAIL starve_cycle%0d: got %b expected %b", c, starve_o, (c >= 4));
            else n_pass++;
        end
        Pwr = 1'b0;
        tick();
        n_checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, starve_o} !== {1'b1, 5'd12, 32'h1234, 1'b0})
            $display("FAIL starve_release: got %h expected %h", {RegWrite_o, RDaddr_o, RDdata_o, starve_o},
                     {1'b1, 5'd12, 32'h1234, 1'b0});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        Pwr = 1'b1; Paddr = 5'd2; Pdata = 32'h2; Svalid = 1'b1; Saddr = 5'd13; Sdata = 32'hA1;
        tick();
        Saddr = 5'd14; Sdata = 32'hA2;
        tick();
        Svalid = 1'b0;
        n_checks++;
        if (count_o !== 2'd2) $display("FAIL rstmid_fill: got %0d expected 2", count_o);
        else n_pass++;
        Pwr = 1'b0; rst = 1'b1;
        tick();
        n_checks++;
        if ({count_o, RegWrite_o, Sready_o} !== 4'd0)
            $display("FAIL rstmid_edge: got %b expected 0000", {count_o, RegWrite_o, Sready_o});
        else n_pass++;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({RegWrite_o, count_o} !== 3'd0) $display("FAIL rstmid_after%0d: got %b expected 000", c, {RegWrite_o, count_o});
            else n_pass++;
        end
    endtask

    task automatic test_r0();
        Pwr = 1'b0; Svalid = 1'b1; Saddr = 5'd0; Sdata = 32'h77;
        #1;
        n_checks++;
        if (Sready_o !== 1'b1) $display("FAIL r0_ready: got %b expected 1", Sready_o);
        else n_pass++;
        tick();
        Svalid = 1'b0;
        n_checks++;
        if (count_o !== (FILT ? 2'd0 : 2'd1)) $display("FAIL r0_count: got %0d expected %0d", count_o, FILT ? 0 : 1);
        else n_pass++;
        tick();
        n_checks++;
        if ({RegWrite_o, RDaddr_o, RDdata_o} !== (FILT ? {1'b0, 5'd0, 32'h0} : {1'b1, 5'd0, 32'h77}))
            $display("FAIL r0_write: got %h expected %h", {RegWrite_o, RDaddr_o, RDdata_o},
                     (FILT ? {1'b0, 5'd0, 32'h0} : {1'b1, 5'd0, 32'h77}));
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst    = ($urandom_range(0, 49) == 0);
            Pwr    = ($urandom_range(0, 99) < ((c % 200) < 100 ? 75 : 25));
            Paddr  = ADDR_W'($urandom_range(0, 7));
            Pdata  = $urandom;
            Svalid = ($urandom_range(0, 99) < 60);
            Saddr  = ADDR_W'($urandom_range(0, 7));
            Sdata  = $urandom;
            RSaddr = ADDR_W'($urandom_range(0, 7));
            RTaddr = ADDR_W'($urandom_range(0, 7));
            tick();
            n_checks++;
            if (dut_vec !== m_vec())
                $display("FAIL random_c%0d: got %h expected %h (we,addr,data,count,starve,haz,ready)", c, dut_vec, m_vec());
            else n_pass++;
        end
        rst = 1'b0; Pwr = 1'b0; Svalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_primary();
        test_fill();
        test_squash();
        test_starve();
        test_reset_mid();
        test_r0();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
